redundancy_equiv_checker: RTL and testbench

Self-checking stimulus/response engine for the redundant-logic example circuit. It drives all 8 input vectors (a, b, c) into the device under test for a configurable number of sweeps. It compares the three DUT outputs against minimised golden forms (out1 = a&b, out2 = a|b, out3 = a&b&c) and reports pass/fail, a saturating mismatch count and the first failing vector. It sits beside the DUT in the tool's post-optimisation regression flow, proving that CSE/DCE/balancing left the function unchanged.

---
 rtl/redundancy_equiv_checker.sv | 148 ++++++++++++++
 tb/tb_redundancy_equiv_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/redundancy_equiv_checker.sv
// Stimulus/response checker for the redundant-logic example circuit: sweeps all
// {a,b,c} vectors, compares DUT outputs to minimised golden forms, logs mismatches.
module redundancy_equiv_checker #(
  parameter int PASSES  = 4,
  parameter int DUT_LAT = 0,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  output logic             stim_c,
  input  logic             dut_out1,
  input  logic             dut_out2,
  input  logic             dut_out3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_seen,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic [2:0]       first_fail_bits
);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  localparam logic [6:0] LAST_PASS  = 7'(PASSES - 1);
  localparam logic [2:0] LAST_DRAIN = 3'(DUT_LAT - 1);

  state_t     state;
  logic [2:0] idx;
  logic [6:0] passcnt;
  logic [2:0] drain_cnt;

  logic [2:0] gold;
  logic       live_valid;
  logic       cmp_valid;
  logic [2:0] cmp_vec;
  logic [2:0] cmp_exp;
  logic [2:0] diff;
  logic       mismatch;

  // idx is the registered stimulus itself, ordered {a,b,c}
  assign {stim_a, stim_b, stim_c} = idx;
  assign gold       = {idx[2] & idx[1], idx[2] | idx[1], idx[2] & idx[1] & idx[0]};
  assign live_valid = (state == DRIVE);

  generate
    if (DUT_LAT == 0) begin : g_comb
      assign cmp_valid = live_valid;
      assign cmp_vec   = idx;
      assign cmp_exp   = gold;
    end else begin : g_pipe
      logic [6:0] line [DUT_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DUT_LAT; i++) line[i] <= '0;
        end else begin
          line[0] <= {live_valid, idx, gold};
          for (int i = 1; i < DUT_LAT; i++) line[i] <= line[i-1];
        end
      end

      assign {cmp_valid, cmp_vec, cmp_exp} = line[DUT_LAT-1];
    end
  endgenerate

  assign diff     = {dut_out1, dut_out2, dut_out3} ^ cmp_exp;
  assign mismatch = cmp_valid & (|diff);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      passcnt         <= '0;
      drain_cnt       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_seen       <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_bits <= '0;
    end else begin
      done <= 1'b0;

      // The final compare lands on the same edge that enters DONE, so pass folds it in
      if (mismatch) begin
        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
        if (!fail_seen) begin
          fail_seen       <= 1'b1;
          first_fail_vec  <= cmp_vec;
          first_fail_bits <= diff;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state           <= DRIVE;
            busy            <= 1'b1;
            idx             <= '0;
            passcnt         <= '0;
            drain_cnt       <= '0;
            pass            <= 1'b0;
            fail_seen       <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_bits <= '0;
          end
        end
        DRIVE: begin
          if (idx == 3'd7 && passcnt == LAST_PASS) begin
            if (DUT_LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= ~(fail_seen | mismatch);
            end else begin
              state <= DRAIN;
            end
          end else begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) passcnt <= passcnt + 7'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ~(fail_seen | mismatch);
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_redundancy_equiv_checker.sv
// Directed bench for redundancy_equiv_checker: three checker instances (comb, 2-cycle
// latency, 2-bit error counter) each paired with a behavioural model of the redundant DUT.
module tb_redundancy_equiv_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v;
  logic [2:0] busy_v, done_v, pass_v, fs_v;
  logic [2:0] st0, st1, st2;
  logic [2:0] resp0, resp1, resp2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [2:0] ffv0, ffv1, ffv2, ffb0, ffb1, ffb2;
  logic [1:0] mode;
  logic [2:0] r1_0, r2_0, r1_1, r2_1;

  int checks   = 0;
  int failures = 0;

  // The circuit as written before optimisation, with its redundant terms
  function automatic logic [2:0] redund(input logic [2:0] v);
    logic a, b, c;
    {a, b, c} = v;
    return {(a & b) | (a & b & c), a | (~a & b), a & b & c};
  endfunction

  always @(posedge clk) begin
    r1_0 <= redund(st0);
    r2_0 <= r1_0;
    r1_1 <= redund(st1);
    r2_1 <= r1_1;
  end

  always_comb begin
    resp0 = redund(st0);
    case (mode)
      2'd0: resp0 = redund(st0);
      2'd1: resp0 = redund(st0) & 3'b110;
      2'd2: resp0 = ~redund(st0);
      default: resp0 = r2_0;
    endcase
  end
  assign resp1 = r2_1;
  assign resp2 = ~redund(st2);

  redundancy_equiv_checker #(.PASSES(4), .DUT_LAT(0), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .stim_a(st0[2]), .stim_b(st0[1]), .stim_c(st0[0]),
    .dut_out1(resp0[2]), .dut_out2(resp0[1]), .dut_out3(resp0[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_seen(fs_v[0]),
    .err_count(err0), .first_fail_vec(ffv0), .first_fail_bits(ffb0)
  );

  redundancy_equiv_checker #(.PASSES(4), .DUT_LAT(2), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .stim_a(st1[2]), .stim_b(st1[1]), .stim_c(st1[0]),
    .dut_out1(resp1[2]), .dut_out2(resp1[1]), .dut_out3(resp1[0]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_seen(fs_v[1]),
    .err_count(err1), .first_fail_vec(ffv1), .first_fail_bits(ffb1)
  );

  redundancy_equiv_checker #(.PASSES(4), .DUT_LAT(0), .ERR_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]),
    .stim_a(st2[2]), .stim_b(st2[1]), .stim_c(st2[0]),
    .dut_out1(resp2[2]), .dut_out2(resp2[1]), .dut_out3(resp2[0]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail_seen(fs_v[2]),
    .err_count(err2), .first_fail_vec(ffv2), .first_fail_bits(ffb2)
  );

  function automatic logic [2:0] stimOf(input int u);
    case (u)
      0: return st0;
      1: return st1;
      default: return st2;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulses (or holds until DONE) start on one instance and observes the run to DONE+4
  task automatic applyStimulus(input int u, input bit hold, output int done_cyc,
                               output int busy_cnt, output int pulses,
                               output logic [2:0] stim0, output logic [2:0] stim11,
                               output logic [2:0] stim_after);
    @(negedge clk);
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[u] = 1'b0;
    done_cyc = -1; busy_cnt = 0; pulses = 0;
    stim0 = 3'b111; stim11 = 3'b000; stim_after = 3'b111;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (busy_v[u]) busy_cnt++;
      if (k == 0) stim0 = stimOf(u);
      if (k == 11) stim11 = stimOf(u);
      if (done_v[u]) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = k;
          start_v[u] = 1'b0;
        end
      end
      if (done_cyc >= 0 && k == done_cyc + 1) stim_after = stimOf(u);
      if (done_cyc >= 0 && k == done_cyc + 4) break;
    end
    start_v[u] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dc, bc, pc, ndone;
    logic [2:0] s0, s11, sa;
    bit seen;

    rst = 1'b1; start_v = '0; mode = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy_v), 32'd0);
    checkOutput("rst_done", 32'(done_v), 32'd0);
    checkOutput("rst_pass", 32'(pass_v), 32'd0);
    checkOutput("rst_fail_seen", 32'(fs_v), 32'd0);
    checkOutput("rst_err", 32'({err0, err2}), 32'd0);
    checkOutput("rst_ffv", 32'({ffv0, ffb0}), 32'd0);
    checkOutput("rst_stim", 32'({st0, st1, st2}), 32'd0);
    rst = 1'b0;

    // Correct combinational DUT
    mode = 2'd0;
    applyStimulus(0, 1'b0, dc, bc, pc, s0, s11, sa);
    checkOutput("ok_done_cycle", 32'(dc), 32'd32);
    checkOutput("ok_busy_len", 32'(bc), 32'd32);
    checkOutput("ok_done_pulses", 32'(pc), 32'd1);
    checkOutput("ok_stim_c0", 32'(s0), 32'd0);
    checkOutput("ok_stim_c11", 32'(s11), 32'd3);
    checkOutput("ok_stim_after", 32'(sa), 32'd0);
    checkOutput("ok_pass", 32'(pass_v[0]), 32'd1);
    checkOutput("ok_err", 32'(err0), 32'd0);
    checkOutput("ok_fail_seen", 32'(fs_v[0]), 32'd0);

    // out3 stuck at 0: only vector 7 differs, once per pass
    mode = 2'd1;
    applyStimulus(0, 1'b0, dc, bc, pc, s0, s11, sa);
    checkOutput("stuck_err", 32'(err0), 32'd4);
    checkOutput("stuck_ffv", 32'(ffv0), 32'd7);
    checkOutput("stuck_ffb", 32'(ffb0), 32'd1);
    checkOutput("stuck_pass", 32'(pass_v[0]), 32'd0);
    checkOutput("stuck_fail_seen", 32'(fs_v[0]), 32'd1);

    // Two-stage registered DUT against a checker that expects that latency
    applyStimulus(1, 1'b0, dc, bc, pc, s0, s11, sa);
    checkOutput("lat2_done_cycle", 32'(dc), 32'd34);
    checkOutput("lat2_busy_len", 32'(bc), 32'd34);
    checkOutput("lat2_pass", 32'(pass_v[1]), 32'd1);
    checkOutput("lat2_err", 32'(err1), 32'd0);

    // Same registered DUT against a zero-latency checker: response lags by two vectors
    mode = 2'd3;
    applyStimulus(0, 1'b0, dc, bc, pc, s0, s11, sa);
    checkOutput("lag_pass", 32'(pass_v[0]), 32'd0);
    checkOutput("lag_err", 32'(err0), 32'd22);
    checkOutput("lag_ffv", 32'(ffv0), 32'd2);
    checkOutput("lag_ffb", 32'(ffb0), 32'd2);

    // Inverted DUT into a 2-bit counter: saturates at 3
    applyStimulus(2, 1'b0, dc, bc, pc, s0, s11, sa);
    checkOutput("inv_err_sat", 32'(err2), 32'd3);
    checkOutput("inv_ffv", 32'(ffv2), 32'd0);
    checkOutput("inv_ffb", 32'(ffb2), 32'd7);
    checkOutput("inv_pass", 32'(pass_v[2]), 32'd0);

    // Reset at cycle 10 of a failing run
    mode = 2'd1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    ndone = 0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    checkOutput("abort_err_before", 32'(err0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("abort_done", 32'(done_v[0]), 32'd0);
    checkOutput("abort_results", 32'({pass_v[0], fs_v[0], err0, ffv0, ffb0}), 32'd0);
    checkOutput("abort_stim", 32'(st0), 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    checkOutput("abort_no_done", 32'(ndone), 32'd0);
    mode = 2'd0;
    applyStimulus(0, 1'b0, dc, bc, pc, s0, s11, sa);
    checkOutput("abort_rerun_done", 32'(dc), 32'd32);
    checkOutput("abort_rerun_pass", 32'(pass_v[0]), 32'd1);

    // start held through a whole run, released in the DONE cycle: exactly one run
    mode = 2'd1;
    applyStimulus(0, 1'b1, dc, bc, pc, s0, s11, sa);
    checkOutput("hold_pulses", 32'(pc), 32'd1);
    checkOutput("hold_busy_len", 32'(bc), 32'd32);
    checkOutput("hold_err", 32'(err0), 32'd4);

    // start held through DONE and the following IDLE cycle: second run clears results
    @(negedge clk);
    start_v[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (done_v[0]) seen = 1'b1;
    end
    checkOutput("restart_first_done", 32'(seen), 32'd1);
    mode = 2'd0;
    @(negedge clk);
    checkOutput("restart_idle_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("restart_idle_err", 32'(err0), 32'd4);
    @(negedge clk);
    start_v[0] = 1'b0;
    checkOutput("restart_busy", 32'(busy_v[0]), 32'd1);
    checkOutput("restart_cleared", 32'({pass_v[0], fs_v[0], err0, ffv0, ffb0}), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (done_v[0]) seen = 1'b1;
    end
    checkOutput("restart_second_done", 32'(seen), 32'd1);
    checkOutput("restart_pass", 32'(pass_v[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
